// File: rtl/reg_writeback_ctrl_if.sv
// rtl/reg_writeback_ctrl_if.sv - bundled ALU/load/memory/register-file signals of the writeback controller
interface reg_writeback_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [IDX_W-1:0]  alu_dest;
    logic [DATA_W-1:0] alu_data;

    logic              ld_start;
    logic [IDX_W-1:0]  ld_dest;
    logic [2:0]        ld_type;
    logic [1:0]        ld_offset;
    logic [DATA_W-1:0] mem_readdata;
    logic              mem_waitrequest;
    logic              busy;

    logic [IDX_W-1:0]  hazard_idx1;
    logic [IDX_W-1:0]  hazard_idx2;
    logic              hazard;
    logic              protocol_err;

    logic              rf_write_enable;
    logic [IDX_W-1:0]  rf_write_reg;
    logic [DATA_W-1:0] rf_write_data;

    // Execute/memory/decode side: drives results and read indices, observes status
    modport master (
        output alu_valid, alu_dest, alu_data,
        output ld_start, ld_dest, ld_type, ld_offset, mem_readdata, mem_waitrequest,
        output hazard_idx1, hazard_idx2,
        input  alu_ready, busy, hazard, protocol_err,
        input  rf_write_enable, rf_write_reg, rf_write_data
    );

    // Writeback controller side
    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  ld_start, ld_dest, ld_type, ld_offset, mem_readdata, mem_waitrequest,
        input  hazard_idx1, hazard_idx2,
        output alu_ready, busy, hazard, protocol_err,
        output rf_write_enable, rf_write_reg, rf_write_data
    );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// rtl/reg_writeback_ctrl.sv - register file write port arbiter for ALU and load results
module reg_writeback_ctrl #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    reg_writeback_ctrl_if.slave  bus
);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    state_t            state_q, state_d;

    logic [IDX_W-1:0]  ld_dest_q, ld_dest_d;
    logic [2:0]        ld_type_q, ld_type_d;
    logic [1:0]        ld_offset_q, ld_offset_d;

    // One-entry holding slot for an ALU result that lost the port to a load
    logic              buf_valid_q, buf_valid_d;
    logic [IDX_W-1:0]  buf_dest_q, buf_dest_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;

    logic              rf_we_q, rf_we_d;
    logic [IDX_W-1:0]  rf_reg_q, rf_reg_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

    logic              perr_q, perr_d;

    logic              busy;
    logic              alu_fire;
    logic              ld_done;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] ld_ext;

    assign busy     = (state_q == WAIT_MEM);
    assign alu_fire = bus.alu_valid & ~buf_valid_q;
    assign ld_done  = busy & ~bus.mem_waitrequest;

    assign bus.busy            = busy;
    assign bus.alu_ready       = ~buf_valid_q;
    assign bus.protocol_err    = perr_q;
    assign bus.rf_write_enable = rf_we_q;
    assign bus.rf_write_reg    = rf_reg_q;
    assign bus.rf_write_data   = rf_data_q;

    // Load FSM next state: accept a load when idle, leave on the first ready beat
    always_comb begin
        state_d     = state_q;
        ld_dest_d   = ld_dest_q;
        ld_type_d   = ld_type_q;
        ld_offset_d = ld_offset_q;
        perr_d      = perr_q;
        case (state_q)
            IDLE: begin
                if (bus.ld_start) begin
                    state_d     = WAIT_MEM;
                    ld_dest_d   = bus.ld_dest;
                    ld_type_d   = bus.ld_type;
                    ld_offset_d = bus.ld_offset;
                end
            end
            WAIT_MEM: begin
                if (bus.ld_start) begin
                    perr_d = 1'b1;
                end
                if (!bus.mem_waitrequest) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane selection and sign/zero extension of the returning load data
    always_comb begin
        byte_sel = bus.mem_readdata[{ld_offset_q, 3'b000} +: 8];
        half_sel = ld_offset_q[1] ? bus.mem_readdata[31:16] : bus.mem_readdata[15:0];
        case (ld_type_q)
            LD_LB:   ld_ext = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LD_LBU:  ld_ext = {{(DATA_W-8){1'b0}}, byte_sel};
            LD_LH:   ld_ext = {{(DATA_W-16){half_sel[15]}}, half_sel};
            LD_LHU:  ld_ext = {{(DATA_W-16){1'b0}}, half_sel};
            default: ld_ext = bus.mem_readdata;
        endcase
    end

    // Write port arbitration: load beats ALU, buffered ALU drains the cycle after
    always_comb begin
        rf_we_d     = 1'b0;
        rf_reg_d    = rf_reg_q;
        rf_data_d   = rf_data_q;
        buf_valid_d = buf_valid_q;
        buf_dest_d  = buf_dest_q;
        buf_data_d  = buf_data_q;
        if (ld_done) begin
            rf_we_d   = (ld_dest_q != '0);
            rf_reg_d  = ld_dest_q;
            rf_data_d = ld_ext;
            if (alu_fire) begin
                buf_valid_d = 1'b1;
                buf_dest_d  = bus.alu_dest;
                buf_data_d  = bus.alu_data;
            end
        end else if (buf_valid_q) begin
            rf_we_d     = (buf_dest_q != '0);
            rf_reg_d    = buf_dest_q;
            rf_data_d   = buf_data_q;
            buf_valid_d = 1'b0;
        end else if (alu_fire) begin
            rf_we_d   = (bus.alu_dest != '0);
            rf_reg_d  = bus.alu_dest;
            rf_data_d = bus.alu_data;
        end
    end

    // Read-after-write hazard against every write not yet visible in the register file
    always_comb begin
        bus.hazard = 1'b0;
        if (bus.hazard_idx1 != '0) begin
            if ((busy && bus.hazard_idx1 == ld_dest_q) ||
                (buf_valid_q && bus.hazard_idx1 == buf_dest_q) ||
                (rf_we_q && bus.hazard_idx1 == rf_reg_q)) begin
                bus.hazard = 1'b1;
            end
        end
        if (bus.hazard_idx2 != '0) begin
            if ((busy && bus.hazard_idx2 == ld_dest_q) ||
                (buf_valid_q && bus.hazard_idx2 == buf_dest_q) ||
                (rf_we_q && bus.hazard_idx2 == rf_reg_q)) begin
                bus.hazard = 1'b1;
            end
        end
    end

    // State and datapath registers; reset drops any outstanding load without writing
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ld_dest_q   <= '0;
            ld_type_q   <= '0;
            ld_offset_q <= '0;
            buf_valid_q <= 1'b0;
            buf_dest_q  <= '0;
            buf_data_q  <= '0;
            rf_we_q     <= 1'b0;
            rf_reg_q    <= '0;
            rf_data_q   <= '0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_dest_q   <= ld_dest_d;
            ld_type_q   <= ld_type_d;
            ld_offset_q <= ld_offset_d;
            buf_valid_q <= buf_valid_d;
            buf_dest_q  <= buf_dest_d;
            buf_data_q  <= buf_data_d;
            rf_we_q     <= rf_we_d;
            rf_reg_q    <= rf_reg_d;
            rf_data_q   <= rf_data_d;
            perr_q      <= perr_d;
        end
    end

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// tb/tb_reg_writeback_ctrl.sv - vector table and scoreboard bench for reg_writeback_ctrl
module tb_reg_writeback_ctrl;

    logic clk;
    logic reset;

    reg_writeback_ctrl_if #(.DATA_W(32), .IDX_W(5)) bus ();

    reg_writeback_ctrl #(.DATA_W(32), .IDX_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_alu;
        logic [4:0]  dest;
        logic [2:0]  ltype;
        logic [1:0]  off;
        logic [31:0] din;
        int          waits;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    vec_t vecs[$];
    wr_t  sb[$];
    wr_t  mon_e;
    int   nvec = 0;
    int   nerr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every register file write must match the oldest expected write, in order
    always @(negedge clk) begin
        if (!reset && bus.rf_write_enable === 1'b1) begin
            if (sb.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_write: got reg %0d data 0x%08h expected no write",
                         bus.rf_write_reg, bus.rf_write_data);
            end else begin
                mon_e = sb.pop_front();
                check("wr_reg", {27'd0, bus.rf_write_reg}, {27'd0, mon_e.r});
                check("wr_data", bus.rf_write_data, mon_e.d);
            end
        end
    end

    task automatic do_alu(input logic [4:0] dest, input logic [31:0] data);
        check("alu_ready_before", {31'd0, bus.alu_ready}, 32'd1);
        bus.alu_valid = 1'b1;
        bus.alu_dest  = dest;
        bus.alu_data  = data;
        if (dest != 5'd0) sb.push_back('{dest, data});
        tick();
        bus.alu_valid = 1'b0;
    endtask

    task automatic do_load(input logic [4:0] dest, input logic [2:0] ltype, input logic [1:0] off,
                           input logic [31:0] data, input int waits, input logic [31:0] exp);
        int busy_cnt;
        busy_cnt = 0;
        bus.ld_start        = 1'b1;
        bus.ld_dest         = dest;
        bus.ld_type         = ltype;
        bus.ld_offset       = off;
        bus.mem_waitrequest = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        for (int i = 0; i < waits; i++) begin
            if (bus.busy) busy_cnt++;
            tick();
        end
        if (bus.busy) busy_cnt++;
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata    = data;
        if (dest != 5'd0) sb.push_back('{dest, exp});
        tick();
        bus.mem_waitrequest = 1'b1;
        check("busy_cycles", busy_cnt, waits + 1);
        check("busy_after_load", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        reset               = 1'b1;
        bus.alu_valid       = 1'b0;
        bus.alu_dest        = '0;
        bus.alu_data        = '0;
        bus.ld_start        = 1'b0;
        bus.ld_dest         = '0;
        bus.ld_type         = '0;
        bus.ld_offset       = '0;
        bus.mem_readdata    = '0;
        bus.mem_waitrequest = 1'b1;
        bus.hazard_idx1     = '0;
        bus.hazard_idx2     = '0;

        vecs.push_back('{1'b1, 5'd3,  3'd0, 2'd0, 32'h12345678, 0, 32'h12345678});
        vecs.push_back('{1'b0, 5'd5,  3'd1, 2'd2, 32'h0080FF11, 3, 32'hFFFFFF80});
        vecs.push_back('{1'b0, 5'd5,  3'd2, 2'd2, 32'h0080FF11, 3, 32'h00000080});
        vecs.push_back('{1'b0, 5'd6,  3'd3, 2'd2, 32'h80017FFF, 1, 32'hFFFF8001});
        vecs.push_back('{1'b0, 5'd6,  3'd4, 2'd0, 32'h80017FFF, 0, 32'h00007FFF});
        vecs.push_back('{1'b0, 5'd6,  3'd0, 2'd1, 32'h80017FFF, 2, 32'h80017FFF});
        vecs.push_back('{1'b0, 5'd8,  3'd1, 2'd1, 32'h0080FF11, 0, 32'hFFFFFFFF});
        vecs.push_back('{1'b0, 5'd8,  3'd2, 2'd0, 32'h0080FF11, 0, 32'h00000011});
        vecs.push_back('{1'b0, 5'd11, 3'd3, 2'd3, 32'h80017FFF, 1, 32'hFFFF8001});
        vecs.push_back('{1'b0, 5'd11, 3'd4, 2'd2, 32'h80017FFF, 0, 32'h00008001});
        vecs.push_back('{1'b0, 5'd12, 3'd6, 2'd3, 32'hA5A55A5A, 0, 32'hA5A55A5A});
        vecs.push_back('{1'b1, 5'd10, 3'd0, 2'd0, 32'hDEADBEEF, 0, 32'hDEADBEEF});

        repeat (3) tick();
        reset = 1'b0;
        check("rst_we",    {31'd0, bus.rf_write_enable}, 32'd0);
        check("rst_reg",   {27'd0, bus.rf_write_reg}, 32'd0);
        check("rst_data",  bus.rf_write_data, 32'd0);
        check("rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("rst_ready", {31'd0, bus.alu_ready}, 32'd1);
        check("rst_perr",  {31'd0, bus.protocol_err}, 32'd0);
        check("rst_hazard", {31'd0, bus.hazard}, 32'd0);
        tick();

        foreach (vecs[k]) begin
            if (vecs[k].is_alu) begin
                do_alu(vecs[k].dest, vecs[k].din);
                check("alu_we", {31'd0, bus.rf_write_enable}, 32'd1);
            end else begin
                do_load(vecs[k].dest, vecs[k].ltype, vecs[k].off, vecs[k].din,
                        vecs[k].waits, vecs[k].exp);
            end
            tick();
            check("write_one_cycle", {31'd0, bus.rf_write_enable}, 32'd0);
        end

        // Load r7 and ALU r9 arrive on the same edge
        bus.ld_start        = 1'b1;
        bus.ld_dest         = 5'd7;
        bus.ld_type         = 3'd0;
        bus.ld_offset       = 2'd0;
        bus.mem_waitrequest = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        tick();
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata    = 32'h13579BDF;
        bus.alu_valid       = 1'b1;
        bus.alu_dest        = 5'd9;
        bus.alu_data        = 32'h000000AA;
        sb.push_back('{5'd7, 32'h13579BDF});
        sb.push_back('{5'd9, 32'h000000AA});
        tick();
        bus.mem_waitrequest = 1'b1;
        bus.alu_valid       = 1'b0;
        check("coll_ready_low", {31'd0, bus.alu_ready}, 32'd0);
        check("coll_reg_first", {27'd0, bus.rf_write_reg}, 32'd7);
        bus.hazard_idx1 = 5'd9;
        #1;
        check("coll_hazard_buf", {31'd0, bus.hazard}, 32'd1);
        bus.hazard_idx1 = 5'd0;
        tick();
        check("coll_ready_back", {31'd0, bus.alu_ready}, 32'd1);
        check("coll_we_second", {31'd0, bus.rf_write_enable}, 32'd1);
        check("coll_reg_second", {27'd0, bus.rf_write_reg}, 32'd9);
        check("coll_data_second", bus.rf_write_data, 32'h000000AA);
        tick();
        check("coll_idle", {31'd0, bus.rf_write_enable}, 32'd0);

        // Hazard, protocol error and r0 writes while a load to r4 is pending
        bus.ld_start        = 1'b1;
        bus.ld_dest         = 5'd4;
        bus.ld_type         = 3'd0;
        bus.mem_waitrequest = 1'b1;
        tick();
        bus.ld_start    = 1'b0;
        bus.hazard_idx1 = 5'd4;
        #1;
        check("hz_idx1_pending", {31'd0, bus.hazard}, 32'd1);
        bus.hazard_idx1 = 5'd0;
        bus.hazard_idx2 = 5'd0;
        #1;
        check("hz_idx_zero", {31'd0, bus.hazard}, 32'd0);
        bus.hazard_idx2 = 5'd4;
        #1;
        check("hz_idx2_pending", {31'd0, bus.hazard}, 32'd1);
        bus.hazard_idx2 = 5'd3;
        #1;
        check("hz_other_idx", {31'd0, bus.hazard}, 32'd0);
        bus.hazard_idx2 = 5'd0;
        bus.ld_start    = 1'b1;
        bus.ld_dest     = 5'd15;
        tick();
        bus.ld_start = 1'b0;
        check("perr_set", {31'd0, bus.protocol_err}, 32'd1);
        check("perr_still_busy", {31'd0, bus.busy}, 32'd1);
        do_alu(5'd0, 32'hFFFFFFFF);
        check("r0_no_write", {31'd0, bus.rf_write_enable}, 32'd0);
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata    = 32'hCAFEF00D;
        sb.push_back('{5'd4, 32'hCAFEF00D});
        tick();
        bus.mem_waitrequest = 1'b1;
        bus.hazard_idx1     = 5'd4;
        #1;
        check("hz_rf_write", {31'd0, bus.hazard}, 32'd1);
        bus.hazard_idx1 = 5'd0;
        tick();
        check("perr_sticky", {31'd0, bus.protocol_err}, 32'd1);

        // Reset while the memory response arrives abandons the load
        bus.ld_start        = 1'b1;
        bus.ld_dest         = 5'd6;
        bus.mem_waitrequest = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        check("rl_busy", {31'd0, bus.busy}, 32'd1);
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata    = 32'h55555555;
        reset               = 1'b1;
        tick();
        reset               = 1'b0;
        bus.mem_waitrequest = 1'b1;
        check("rl_busy_cleared", {31'd0, bus.busy}, 32'd0);
        check("rl_no_write", {31'd0, bus.rf_write_enable}, 32'd0);
        check("rl_perr_cleared", {31'd0, bus.protocol_err}, 32'd0);
        check("rl_ready", {31'd0, bus.alu_ready}, 32'd1);
        tick();
        check("rl_no_late_write", {31'd0, bus.rf_write_enable}, 32'd0);

        repeat (3) tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
